// File: rtl/serial_alu_seq.sv
// Bit-serial ALU: one full adder plus a logic slice, stepped LSB first over WIDTH cycles.
// A two-state controller (IDLE/RUN) sequences the shift registers, carry flop and bit counter.
module serial_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] OPA,
    input  logic [WIDTH-1:0] OPB,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             COUT,
    output logic             dbgState
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLTU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } stateT;

    stateT state;
    stateT nextState;

    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic [2:0]       opReg;
    logic [WIDTH-1:0] resultReg;
    logic [CNT_W-1:0] bitCnt;
    logic             carry;
    logic             coutReg;
    logic             doneReg;

    logic invertB;
    logic isArith;
    logic bBit;
    logic sumBit;
    logic carryNext;
    logic sliceBit;
    logic lastBit;

    // Handshake: START is sampled only in IDLE; DONE pulses for one cycle once
    // RESULT/COUT hold the finished value, and START in that same cycle is accepted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (START)   nextState = RUN;
            RUN:     if (lastBit) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        BUSY     = (state == RUN);
        dbgState = state;
    end

    // One bit of the serial datapath; subtraction forms A + ~B + 1.
    always_comb begin
        invertB   = (opReg == OP_SUB) || (opReg == OP_SLTU);
        isArith   = (opReg == OP_ADD) || invertB;
        bBit      = bReg[0] ^ invertB;
        sumBit    = aReg[0] ^ bBit ^ carry;
        carryNext = (aReg[0] & bBit) | (carry & (aReg[0] ^ bBit));
        lastBit   = (bitCnt == CNT_W'(WIDTH - 1));
        sliceBit  = 1'b0;
        case (opReg)
            OP_ADD, OP_SUB: sliceBit = sumBit;
            OP_AND:         sliceBit = aReg[0] & bReg[0];
            OP_OR:          sliceBit = aReg[0] | bReg[0];
            OP_XOR:         sliceBit = aReg[0] ^ bReg[0];
            default:        sliceBit = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            aReg      <= '0;
            bReg      <= '0;
            opReg     <= '0;
            resultReg <= '0;
            bitCnt    <= '0;
            carry     <= 1'b0;
            coutReg   <= 1'b0;
            doneReg   <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            if (state == IDLE && START) begin
                aReg   <= OPA;
                bReg   <= OPB;
                opReg  <= OP;
                bitCnt <= '0;
                carry  <= (OP == OP_SUB) || (OP == OP_SLTU);
            end else if (state == RUN) begin
                aReg      <= aReg >> 1;
                bReg      <= bReg >> 1;
                bitCnt    <= bitCnt + CNT_W'(1);
                carry     <= carryNext;
                resultReg <= {sliceBit, resultReg[WIDTH-1:1]};
                if (lastBit) begin
                    doneReg <= 1'b1;
                    bitCnt  <= '0;
                    coutReg <= isArith ? carryNext : 1'b0;
                    // SLTU reports borrow: no final carry means A < B.
                    if (opReg == OP_SLTU) begin
                        resultReg <= WIDTH'(!carryNext);
                    end
                end
            end
        end
    end

    assign RESULT = resultReg;
    assign COUT   = coutReg;
    assign DONE   = doneReg;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Bench for serial_alu_seq at WIDTH=8: directed scenarios plus random operations
// scored against an arithmetic reference model.
module tb_serial_alu_seq;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic [2:0]   OP;
    logic [W-1:0] OPA;
    logic [W-1:0] OPB;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] RESULT;
    logic         COUT;
    logic         dbgState;

    int vecCount = 0;
    int errCount = 0;
    logic [W:0] exp_q[$];

    serial_alu_seq #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .START(START), .OP(OP), .OPA(OPA), .OPB(OPB),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .COUT(COUT), .dbgState(dbgState)
    );

    always #5 CLK = ~CLK;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {cout, result} straight from the operation definitions.
    function automatic logic [W:0] refModel(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [W-1:0] lt;
        lt = (a < b) ? W'(1) : W'(0);
        case (op)
            3'd0:    refModel = {1'b0, a} + {1'b0, b};
            3'd1:    refModel = {(a >= b), W'(a - b)};
            3'd2:    refModel = {1'b0, a & b};
            3'd3:    refModel = {1'b0, a | b};
            3'd4:    refModel = {1'b0, a ^ b};
            3'd5:    refModel = {(a >= b), lt};
            default: refModel = '0;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic waitDone(output int busyCnt);
        busyCnt = 0;
        while (BUSY && busyCnt < 50) begin
            busyCnt++;
            tick();
        end
    endtask

    task automatic checkDone(input string tag);
        logic [W:0] e;
        checkVal({tag, "_done"}, DONE, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checkVal({tag, "_result"}, RESULT, e[W-1:0]);
        checkVal({tag, "_cout"}, COUT, e[W]);
    endtask

    task automatic runOp(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        int busyCnt;
        exp_q.push_back(refModel(op, a, b));
        OP = op; OPA = a; OPB = b; START = 1'b1;
        tick();
        START = 1'b0;
        OPA = W'($urandom); OPB = W'($urandom);
        waitDone(busyCnt);
        checkVal({tag, "_busy_cycles"}, busyCnt, W);
        checkDone(tag);
        tick();
        checkVal({tag, "_done_low"}, DONE, 0);
    endtask

    initial begin
        int busyCnt;
        int hits;
        int pulseAt[$];
        RST = 1'b1; START = 1'b0; OP = '0; OPA = '0; OPB = '0;
        tick(); tick();
        RST = 1'b0;
        checkVal("rst_busy", BUSY, 0);
        checkVal("rst_done", DONE, 0);
        checkVal("rst_result", RESULT, 0);
        checkVal("rst_cout", COUT, 0);

        // Reset overrides a simultaneous START.
        RST = 1'b1; START = 1'b1; OP = 3'd0; OPA = 8'h12; OPB = 8'h34;
        tick();
        RST = 1'b0; START = 1'b0;
        checkVal("rst_over_start", BUSY, 0);

        runOp("add_wrap", 3'd0, 8'hFF, 8'h01);
        runOp("sub_neg", 3'd1, 8'h05, 8'h07);
        runOp("sltu_lt", 3'd5, 8'h05, 8'h07);
        runOp("sltu_ge", 3'd5, 8'h07, 8'h05);
        runOp("sltu_eq", 3'd5, 8'h80, 8'h80);
        runOp("sub_eq", 3'd1, 8'h80, 8'h80);
        runOp("xor", 3'd4, 8'hA5, 8'h0F);
        runOp("and", 3'd2, 8'hA5, 8'h0F);
        runOp("or", 3'd3, 8'hA5, 8'h0F);
        runOp("rsvd6", 3'd6, 8'hFF, 8'hFF);
        runOp("rsvd7", 3'd7, 8'hA5, 8'h0F);

        // START during RUN must be ignored.
        exp_q.push_back(refModel(3'd0, 8'h10, 8'h20));
        OP = 3'd0; OPA = 8'h10; OPB = 8'h20; START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        OP = 3'd1; OPA = 8'hFF; OPB = 8'h77; START = 1'b1;
        tick();
        START = 1'b0;
        waitDone(busyCnt);
        checkVal("ignore_busy_cycles", busyCnt + 2, W);
        checkDone("ignore");
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (DONE || BUSY) hits++;
        end
        checkVal("ignore_no_second_op", hits, 0);

        // Abort mid-operation with reset.
        OP = 3'd0; OPA = 8'h55; OPB = 8'h33; START = 1'b1;
        tick();
        START = 1'b0;
        tick(); tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checkVal("abort_busy", BUSY, 0);
        checkVal("abort_result", RESULT, 0);
        checkVal("abort_done", DONE, 0);
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (DONE) hits++;
        end
        checkVal("abort_no_done", hits, 0);
        runOp("after_abort", 3'd0, 8'h01, 8'h02);

        // START held high: back-to-back operations.
        OP = 3'd0; OPA = 8'h01; OPB = 8'h01; START = 1'b1;
        for (int c = 1; c <= 60 && pulseAt.size() < 3; c++) begin
            tick();
            if (DONE) begin
                pulseAt.push_back(c);
                exp_q.push_back(refModel(3'd0, 8'h01, 8'h01));
                checkDone("b2b");
                if (pulseAt.size() == 3) START = 1'b0;
            end
        end
        checkVal("b2b_pulses", pulseAt.size(), 3);
        if (pulseAt.size() == 3) begin
            checkVal("b2b_gap1", pulseAt[1] - pulseAt[0], W + 1);
            checkVal("b2b_gap2", pulseAt[2] - pulseAt[1], W + 1);
        end
        tick();
        checkVal("b2b_stop_idle", BUSY, 0);

        for (int i = 0; i < 60; i++) begin
            runOp("rand", 3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/serial_alu_seq.md
SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits (legal values 4..32).
REQ-002 SHALL have port: CLK  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: START  input  1  request to begin an operation.
REQ-005 SHALL have port: OP  input  3  operation code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLTU, others reserved.
REQ-006 SHALL have port: OPA  input  WIDTH  operand A.
REQ-007 SHALL have port: OPB  input  WIDTH  operand B.
REQ-008 SHALL have port: BUSY  output  1  operation in progress.
REQ-009 SHALL have port: DONE  output  1  one-cycle pulse, RESULT/COUT valid.
REQ-010 SHALL have port: RESULT  output  WIDTH  operation result.
REQ-011 SHALL have port: COUT  output  1  final carry out of ADD/SUB.
REQ-012 SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-013 SHALL sequence a 1-bit serial datapath (full adder plus AND/OR/XOR slice) over WIDTH cycles, LSB first, using one carry flop and one bit counter.
REQ-014 SHALL have two states: IDLE (BUSY=0) and RUN (BUSY=1).
REQ-015 In IDLE, START=1 at a rising edge SHALL latch OPA, OPB, OP into internal shift registers, clear the bit counter, load carry (1 for SUB/SLTU, else 0), and enter RUN.
REQ-016 START while BUSY=1 SHALL be ignored; operands and OP SHALL NOT be re-sampled.
REQ-017 In RUN, each rising edge SHALL process one bit, shift the result bit into RESULT from the MSB side, update carry, and increment the counter.
REQ-018 SUB and SLTU SHALL use inverted B bits with carry-in 1 (A + ~B + 1).
REQ-019 After the WIDTH-th RUN edge the block SHALL return to IDLE and assert DONE for exactly one cycle; BUSY SHALL be high for exactly WIDTH cycles per operation.
REQ-020 RESULT SHALL be stable and valid from the DONE cycle until the next accepted START; intermediate RESULT values during RUN are undefined for users.
REQ-021 SLTU SHALL produce RESULT = 1 when OPA < OPB unsigned (final carry 0), else 0, with all upper bits zero.
REQ-022 COUT SHALL equal the final carry for ADD/SUB/SLTU and 0 for AND/OR/XOR/reserved, valid under the same rule as RESULT.
REQ-023 Reserved OP codes SHALL complete with normal timing and produce RESULT = 0, COUT = 0.
REQ-024 START=1 in the DONE cycle SHALL be accepted (back-to-back), giving DONE pulses exactly WIDTH+1 cycles apart.
REQ-025 Arithmetic SHALL wrap modulo 2^WIDTH; no overflow flag is produced.

Reset
REQ-026 RST=1 at a rising edge SHALL force IDLE, BUSY=0, DONE=0, RESULT=0, COUT=0, counter=0, carry=0, overriding START.
REQ-027 RST asserted during RUN SHALL abort the operation with no DONE pulse; the first START after RST deasserts SHALL be accepted normally.

Verification (WIDTH=8)
REQ-028 ADD OPA=0xFF, OPB=0x01, START 1 cycle -> BUSY high 8 cycles, DONE next cycle, RESULT=0x00, COUT=1.
REQ-029 SUB OPA=0x05, OPB=0x07 -> RESULT=0xFE, COUT=0; SLTU same operands -> RESULT=0x01; SLTU 0x07,0x05 -> RESULT=0x00.
REQ-030 XOR 0xA5,0x0F -> RESULT=0xAA; AND -> 0x05; OR -> 0xAF; OP=111 -> RESULT=0x00, COUT=0, DONE still after 8 busy cycles.
REQ-031 START with ADD 0x10,0x20, then START with different operands at busy cycle 3 -> ignored, RESULT=0x30, single DONE.
REQ-032 RST asserted at busy cycle 4 -> next cycle BUSY=0, RESULT=0x00, no DONE; new ADD 0x01,0x02 -> RESULT=0x03.
REQ-033 START held high continuously with ADD 0x01,0x01 -> DONE pulses every 9 cycles, each RESULT=0x02.
